// File: rtl/ip_rx_pkg.sv
// Shared constants and FSM encoding for the IPv4 receive layer.
package ip_rx_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [15:0] IP_HDR_LEN    = 16'd20;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [31:0] IP_BCAST      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DROP    = 2'd3
    } ip_rx_state_t;

endpackage

// File: rtl/ip_csum_acc.sv
// 16-bit one's-complement header checksum accumulator, fed one byte at a time.
module ip_csum_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        hi_sel,
    input  logic [7:0]  data,
    output logic [15:0] sum
);

    logic [7:0]  hi_q;
    logic [15:0] acc;
    logic [16:0] raw;

    // sum is the accumulator plus the word completed by the current low byte,
    // so the caller sees the final header sum in the cycle of the last byte.
    always_comb begin
        raw = {1'b0, acc} + {1'b0, hi_q, data};
        sum = raw[15:0] + {15'd0, raw[16]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 8'd0;
            acc  <= 16'd0;
        end else begin
            if (en && hi_sel) begin
                hi_q <= data;
            end
            if (clr) begin
                acc <= 16'd0;
            end else if (en && !hi_sel) begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/ip_rx.sv
// IPv4 receive layer: checks the 20-byte header, forwards the payload with
// protocol/length/source, drops bad frames and trims Ethernet padding.
module ip_rx
    import ip_rx_pkg::*;
#(
    parameter logic [31:0] P_ST_LOCAL_IP  = {8'd192, 8'd168, 8'd1, 8'd0},
    parameter bit          P_ACCEPT_BCAST = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [31:0]  i_local_ip,
    input  logic         i_local_valid,
    input  logic [15:0]  i_mac_type,
    input  logic [15:0]  i_mac_len,
    input  logic [7:0]   i_mac_data,
    input  logic         i_mac_last,
    input  logic         i_mac_valid,
    output logic [7:0]   o_recv_type,
    output logic [15:0]  o_recv_len,
    output logic [31:0]  o_recv_source_ip,
    output logic [7:0]   o_recv_data,
    output logic         o_recv_last,
    output logic         o_recv_valid,
    output logic         o_recv_err,
    output ip_rx_state_t o_dbg_state
);

    // Handshake: valid-only streams, no ready. An input byte is consumed on
    // every edge where i_mac_valid=1; an output byte exists on every edge where
    // o_recv_valid=1. o_recv_last/o_recv_err qualify the byte they accompany.

    ip_rx_state_t state_q, state_d;

    logic        prev_valid, prev_last;
    logic [31:0] local_ip, dst_ref;
    logic [15:0] byte_cnt, pay_cnt, total_len;
    logic [15:0] hdr_idx, csum;
    logic [7:0]  proto, frag_lo;
    logic [5:0]  frag_hi;
    logic [31:0] src_ip;
    logic [23:0] dst_hi;
    logic        ver_ok;

    logic start, fell, byte_last, hdr_en, hdr_done, pay_last;
    logic checks_ok, dst_ok, take_hdr;
    logic fwd, fwd_last, fwd_err;
    logic [31:0] dst_ip;
    logic unused_inputs;

    assign unused_inputs = ^i_mac_len;

    // A byte right after a last is also a start, so back-to-back frames work.
    assign start     = i_mac_valid && (!prev_valid || prev_last);
    assign fell      = !i_mac_valid && prev_valid && !prev_last;
    assign byte_last = i_mac_valid && i_mac_last;

    // Byte 0 arrives in IDLE; the rest of the header in HEADER.
    assign hdr_en   = (state_q == ST_IDLE && start && i_mac_type == ETH_TYPE_IPV4) ||
                      (state_q == ST_HEADER && i_mac_valid);
    assign hdr_idx  = (state_q == ST_IDLE) ? 16'd0 : byte_cnt;
    assign hdr_done = (state_q == ST_HEADER) && i_mac_valid && (byte_cnt == IP_HDR_LEN - 16'd1);

    ip_csum_acc u_csum (
        .clk    (i_clk),
        .rst_n  (i_rst),
        .clr    (state_q == ST_IDLE),
        .en     (hdr_en),
        .hi_sel (!hdr_idx[0]),
        .data   (i_mac_data),
        .sum    (csum)
    );

    assign dst_ip    = {dst_hi, i_mac_data};
    assign dst_ok    = (dst_ip == dst_ref) || (P_ACCEPT_BCAST && dst_ip == IP_BCAST);
    assign checks_ok = ver_ok && (frag_hi == 6'd0) && (frag_lo == 8'd0) && (csum == 16'hFFFF);
    assign pay_last  = (pay_cnt == o_recv_len - 16'd1);

    // A frame that ends inside the header has nothing left to swallow, so it
    // returns to IDLE directly and a back-to-back start is not missed.
    always_comb begin
        state_d  = state_q;
        take_hdr = 1'b0;
        fwd      = 1'b0;
        fwd_last = 1'b0;
        fwd_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (byte_last)                          state_d = ST_IDLE;
                    else if (i_mac_type == ETH_TYPE_IPV4)   state_d = ST_HEADER;
                    else                                    state_d = ST_DROP;
                end
            end
            ST_HEADER: begin
                if (fell) begin
                    state_d = ST_IDLE;
                end else if (hdr_done) begin
                    if (byte_last) begin
                        state_d = ST_IDLE;
                    end else if (checks_ok && total_len > IP_HDR_LEN && dst_ok) begin
                        state_d  = ST_PAYLOAD;
                        take_hdr = 1'b1;
                    end else if (checks_ok && total_len == IP_HDR_LEN) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end else if (byte_last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (i_mac_valid) begin
                    fwd = 1'b1;
                    if (pay_last) begin
                        fwd_last = 1'b1;
                        state_d  = byte_last ? ST_IDLE : ST_DROP;
                    end else if (byte_last) begin
                        fwd_last = 1'b1;
                        fwd_err  = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else if (fell) begin
                    // Truncated by valid falling: flag last+err with no data byte.
                    fwd_last = 1'b1;
                    fwd_err  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (byte_last || fell) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // prev_valid resets to 1 so bytes of a frame cut by reset are not taken as a start.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q          <= ST_IDLE;
            prev_valid       <= 1'b1;
            prev_last        <= 1'b0;
            local_ip         <= P_ST_LOCAL_IP;
            dst_ref          <= P_ST_LOCAL_IP;
            byte_cnt         <= 16'd0;
            pay_cnt          <= 16'd0;
            total_len        <= 16'd0;
            proto            <= 8'd0;
            frag_hi          <= 6'd0;
            frag_lo          <= 8'd0;
            src_ip           <= 32'd0;
            dst_hi           <= 24'd0;
            ver_ok           <= 1'b0;
            o_recv_type      <= 8'd0;
            o_recv_len       <= 16'd0;
            o_recv_source_ip <= 32'd0;
            o_recv_data      <= 8'd0;
            o_recv_last      <= 1'b0;
            o_recv_valid     <= 1'b0;
            o_recv_err       <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_valid <= i_mac_valid;
            prev_last  <= byte_last;
            if (i_local_valid) local_ip <= i_local_ip;
            byte_cnt <= hdr_en ? hdr_idx + 16'd1 : 16'd0;
            if (hdr_en) begin
                case (hdr_idx)
                    16'd0:  ver_ok            <= (i_mac_data == IP_VER_IHL);
                    16'd2:  total_len[15:8]   <= i_mac_data;
                    16'd3:  total_len[7:0]    <= i_mac_data;
                    16'd6:  frag_hi           <= i_mac_data[5:0];
                    16'd7:  frag_lo           <= i_mac_data;
                    16'd9:  proto             <= i_mac_data;
                    16'd12: src_ip[31:24]     <= i_mac_data;
                    16'd13: src_ip[23:16]     <= i_mac_data;
                    16'd14: src_ip[15:8]      <= i_mac_data;
                    16'd15: src_ip[7:0]       <= i_mac_data;
                    16'd16: begin
                        dst_hi[23:16] <= i_mac_data;
                        dst_ref       <= local_ip;
                    end
                    16'd17: dst_hi[15:8]      <= i_mac_data;
                    16'd18: dst_hi[7:0]       <= i_mac_data;
                    default: ;
                endcase
            end
            if (take_hdr) begin
                o_recv_type      <= proto;
                o_recv_len       <= total_len - IP_HDR_LEN;
                o_recv_source_ip <= src_ip;
            end
            if (fwd)                       pay_cnt <= pay_cnt + 16'd1;
            else if (state_q != ST_PAYLOAD) pay_cnt <= 16'd0;
            o_recv_valid <= fwd;
            o_recv_data  <= fwd ? i_mac_data : 8'd0;
            o_recv_last  <= fwd_last;
            o_recv_err   <= fwd_err;
        end
    end

    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_ip_rx.sv
// Self-checking bench for ip_rx: randomized frames scored against a header/payload model.
module tb_ip_rx;
    import ip_rx_pkg::*;

    localparam int W = 66;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [31:0]  i_local_ip;
    logic         i_local_valid;
    logic [15:0]  i_mac_type;
    logic [15:0]  i_mac_len;
    logic [7:0]   i_mac_data;
    logic         i_mac_last;
    logic         i_mac_valid;
    logic [7:0]   o_recv_type;
    logic [15:0]  o_recv_len;
    logic [31:0]  o_recv_source_ip;
    logic [7:0]   o_recv_data;
    logic         o_recv_last;
    logic         o_recv_valid;
    logic         o_recv_err;
    ip_rx_state_t o_dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    logic [7:0]   frm[$];
    logic [31:0]  local_ip_m;
    int           n_pass;
    int           n_checks;

    ip_rx dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_local_ip       (i_local_ip),
        .i_local_valid    (i_local_valid),
        .i_mac_type       (i_mac_type),
        .i_mac_len        (i_mac_len),
        .i_mac_data       (i_mac_data),
        .i_mac_last       (i_mac_last),
        .i_mac_valid      (i_mac_valid),
        .o_recv_type      (o_recv_type),
        .o_recv_len       (o_recv_len),
        .o_recv_source_ip (o_recv_source_ip),
        .o_recv_data      (o_recv_data),
        .o_recv_last      (o_recv_last),
        .o_recv_valid     (o_recv_valid),
        .o_recv_err       (o_recv_err),
        .o_dbg_state      (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    function automatic logic [W-1:0] ent(input logic err, input logic last, input logic [7:0] d,
                                         input logic [7:0] t, input logic [15:0] l, input logic [31:0] s);
        return {err, last, d, t, l, s};
    endfunction

    always @(negedge i_clk) begin
        if (i_rst && (o_recv_valid || o_recv_last || o_recv_err))
            obs_q.push_back(ent(o_recv_err, o_recv_last, o_recv_data, o_recv_type, o_recv_len, o_recv_source_ip));
    end

    // ---------------- frame builder / reference model ----------------
    function automatic logic [15:0] hdr_sum();
        int s = 0;
        for (int i = 0; i < 10; i++) begin
            s = s + int'({frm[2*i], frm[2*i+1]});
            s = (s & 32'hFFFF) + (s >>> 16);
        end
        return s[15:0];
    endfunction

    task automatic make_frame(input logic [15:0] tl, input logic [7:0] b0, input logic [7:0] fl,
                              input logic [7:0] proto, input logic [31:0] src, input logic [31:0] dst,
                              input bit bad, input int n_data);
        logic [15:0] c;
        frm.delete();
        frm.push_back(b0);   frm.push_back(8'h00);
        frm.push_back(tl[15:8]); frm.push_back(tl[7:0]);
        frm.push_back(8'($urandom_range(0, 255))); frm.push_back(8'($urandom_range(0, 255)));
        frm.push_back(fl);   frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(proto);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 3; i >= 0; i--) frm.push_back(src[8*i +: 8]);
        for (int i = 3; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
        c = ~hdr_sum();
        if (bad) c = c + 16'd1;
        frm[10] = c[15:8];
        frm[11] = c[7:0];
        for (int i = 0; i < n_data; i++) frm.push_back(8'($urandom_range(0, 255)));
    endtask

    // Expected upper-layer bytes for the frame currently in frm.
    task automatic model_frame(input logic [15:0] mtype);
        int tl, n, avail, cnt;
        logic [31:0] dst, src;
        bit ok;
        if (mtype != 16'h0800 || frm.size() < 20) return;
        ok  = (frm[0] == 8'h45) && ((frm[6] & 8'h3F) == 8'h00) && (frm[7] == 8'h00) && (hdr_sum() == 16'hFFFF);
        tl  = int'({frm[2], frm[3]});
        src = {frm[12], frm[13], frm[14], frm[15]};
        dst = {frm[16], frm[17], frm[18], frm[19]};
        if (!ok || tl <= 20 || !(dst == local_ip_m || dst == 32'hFFFF_FFFF)) return;
        n     = tl - 20;
        avail = frm.size() - 20;
        cnt   = (avail < n) ? avail : n;
        for (int i = 0; i < cnt; i++)
            exp_q.push_back(ent((i == cnt - 1) && (avail < n), i == cnt - 1, frm[20+i], frm[9], 16'(n), src));
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_frm(input logic [15:0] mtype, input bit idle_after);
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge i_clk);
            i_mac_type  = mtype;
            i_mac_len   = 16'(frm.size());
            i_mac_data  = frm[i];
            i_mac_valid = 1'b1;
            i_mac_last  = (i == frm.size() - 1);
        end
        if (idle_after) begin
            @(negedge i_clk);
            i_mac_valid = 1'b0;
            i_mac_last  = 1'b0;
            i_mac_data  = 8'd0;
        end
    endtask

    task automatic idle(input int n);
        @(negedge i_clk);
        i_mac_valid = 1'b0;
        i_mac_last  = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic set_local(input logic [31:0] ip);
        @(negedge i_clk);
        i_local_ip    = ip;
        i_local_valid = 1'b1;
        @(negedge i_clk);
        i_local_valid = 1'b0;
        local_ip_m    = ip;
    endtask

    task automatic load_spec_frame(input logic [7:0] csum_lo);
        frm = {8'h45, 8'h00, 8'h00, 8'h16, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h06, 8'hB7, csum_lo,
               8'hC0, 8'hA8, 8'h01, 8'h01, 8'hC0, 8'hA8, 8'h01, 8'h00, 8'h01, 8'h02};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if ({o_recv_valid, o_recv_last, o_recv_err, o_recv_data, o_recv_type, o_recv_len, o_recv_source_ip} !== 67'd0)
            $display("FAIL reset_outputs: got v%b l%b e%b d%h t%h len%h src%h want all 0", o_recv_valid, o_recv_last,
                     o_recv_err, o_recv_data, o_recv_type, o_recv_len, o_recv_source_ip);
        else n_pass++;
        n_checks++;
        if (o_dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", o_dbg_state, ST_IDLE);
        else n_pass++;
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
    endtask

    task automatic test_basic();
        load_spec_frame(8'h90);
        exp_q.push_back(ent(1'b0, 1'b0, 8'h01, 8'h06, 16'd2, 32'hC0A8_0101));
        exp_q.push_back(ent(1'b0, 1'b1, 8'h02, 8'h06, 16'd2, 32'hC0A8_0101));
        send_frm(16'h0800, 1'b1);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL basic_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_bad_csum();
        load_spec_frame(8'h91);
        send_frm(16'h0800, 1'b1);
        load_spec_frame(8'h90);
        exp_q.push_back(ent(1'b0, 1'b0, 8'h01, 8'h06, 16'd2, 32'hC0A8_0101));
        exp_q.push_back(ent(1'b0, 1'b1, 8'h02, 8'h06, 16'd2, 32'hC0A8_0101));
        send_frm(16'h0800, 1'b1);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL bad_csum_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL bad_csum_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_padding();
        load_spec_frame(8'h90);
        for (int i = 0; i < 44; i++) frm.push_back(8'($urandom_range(0, 255)));
        exp_q.push_back(ent(1'b0, 1'b0, 8'h01, 8'h06, 16'd2, 32'hC0A8_0101));
        exp_q.push_back(ent(1'b0, 1'b1, 8'h02, 8'h06, 16'd2, 32'hC0A8_0101));
        send_frm(16'h0800, 1'b1);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL padding_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL padding_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_local_ip();
        int n_first;
        make_frame(16'd28, 8'h45, 8'h00, 8'h11, 32'h0A00_0001, 32'hC0A8_0105, 1'b0, 8);
        send_frm(16'h0800, 1'b1);
        idle(3);
        n_first = obs_q.size();
        n_checks++;
        if (n_first != 0) $display("FAIL foreign_dst_count: got %0d want 0", n_first);
        else n_pass++;
        set_local(32'hC0A8_0105);
        model_frame(16'h0800);
        send_frm(16'h0800, 1'b1);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size() || exp_q.size() != 8)
            $display("FAIL local_ip_count: got %0d want %0d", obs_q.size(), 8);
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL local_ip_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
        set_local(32'hC0A8_0100);
    endtask

    task automatic test_truncated();
        make_frame(16'd30, 8'h45, 8'h40, 8'h01, 32'hC0A8_0177, 32'hC0A8_0100, 1'b0, 3);
        model_frame(16'h0800);
        send_frm(16'h0800, 1'b1);
        idle(3);
        n_checks++;
        if (obs_q.size() != 3) $display("FAIL trunc_count: got %0d want 3", obs_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL trunc_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_filters();
        make_frame(16'd26, 8'h45, 8'h00, 8'h06, 32'hC0A8_0102, 32'hC0A8_0100, 1'b0, 6);
        send_frm(16'h0806, 1'b1);
        make_frame(16'd26, 8'h45, 8'h20, 8'h06, 32'hC0A8_0102, 32'hC0A8_0100, 1'b0, 6);
        send_frm(16'h0800, 1'b1);
        make_frame(16'd26, 8'h45, 8'h00, 8'h06, 32'hC0A8_0102, 32'hFFFF_FFFF, 1'b0, 10);
        model_frame(16'h0800);
        send_frm(16'h0800, 1'b1);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL filters_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL filters_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        make_frame(16'd24, 8'h45, 8'h00, 8'h11, 32'hC0A8_0103, 32'hC0A8_0100, 1'b0, 4);
        model_frame(16'h0800);
        send_frm(16'h0800, 1'b0);
        make_frame(16'd24, 8'h45, 8'h00, 8'h11, 32'hC0A8_0103, 32'hC0A8_0100, 1'b0, 9);
        model_frame(16'h0806);
        send_frm(16'h0806, 1'b0);
        make_frame(16'd25, 8'h45, 8'h00, 8'h01, 32'hC0A8_0104, 32'hC0A8_0100, 1'b0, 5);
        model_frame(16'h0800);
        send_frm(16'h0800, 1'b1);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [31:0] src;
        make_frame(16'd60, 8'h45, 8'h00, 8'h11, 32'hC0A8_0150, 32'hC0A8_0100, 1'b0, 40);
        src = {frm[12], frm[13], frm[14], frm[15]};
        for (int i = 0; i < 5; i++) exp_q.push_back(ent(1'b0, 1'b0, frm[20+i], 8'h11, 16'd40, src));
        for (int i = 0; i < frm.size(); i++) begin
            @(negedge i_clk);
            i_mac_type  = 16'h0800;
            i_mac_data  = frm[i];
            i_mac_valid = 1'b1;
            i_mac_last  = (i == frm.size() - 1);
            if (i == 25) begin
                #2 i_rst = 1'b0;
                #1;
                n_checks++;
                if ({o_recv_valid, o_recv_last, o_recv_err, o_recv_data, o_recv_type, o_recv_len, o_recv_source_ip} !== 67'd0
                    || o_dbg_state !== ST_IDLE)
                    $display("FAIL reset_mid_clear: got v%b d%h t%h len%h src%h st%0d want all 0", o_recv_valid,
                             o_recv_data, o_recv_type, o_recv_len, o_recv_source_ip, o_dbg_state);
                else n_pass++;
            end
            if (i == 27) #2 i_rst = 1'b1;
        end
        make_frame(16'd23, 8'h45, 8'h00, 8'h06, 32'hC0A8_0151, 32'hC0A8_0100, 1'b0, 3);
        model_frame(16'h0800);
        send_frm(16'h0800, 1'b1);
        idle(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL reset_mid_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL reset_mid_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [15:0] mtype;
        logic [7:0]  b0, fl;
        logic [31:0] dst;
        int plen, n_data, pick;
        for (int f = 0; f < 30; f++) begin
            mtype = ($urandom_range(0, 7) == 0) ? 16'h0806 : 16'h0800;
            plen  = $urandom_range(0, 30);
            b0    = ($urandom_range(0, 9) == 0) ? 8'h46 : 8'h45;
            pick  = $urandom_range(0, 7);
            fl    = (pick == 0) ? 8'h20 : (pick == 1) ? 8'h01 : (pick < 4) ? 8'h40 : 8'h00;
            pick  = $urandom_range(0, 5);
            dst   = (pick == 0) ? 32'hFFFF_FFFF : (pick == 1) ? 32'($urandom) : local_ip_m;
            if (plen > 1 && $urandom_range(0, 4) == 0) n_data = $urandom_range(1, plen - 1);
            else n_data = plen + $urandom_range(0, 12);
            make_frame(16'(20 + plen), b0, fl, 8'($urandom_range(0, 255)), 32'($urandom), dst,
                       $urandom_range(0, 5) == 0, n_data);
            model_frame(mtype);
            send_frm(mtype, 1'($urandom_range(0, 1)));
        end
        idle(4);
        n_checks++;
        if (obs_q.size() != exp_q.size()) $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL random_byte%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        n_pass        = 0;
        n_checks      = 0;
        local_ip_m    = 32'hC0A8_0100;
        i_rst         = 1'b0;
        i_local_ip    = 32'd0;
        i_local_valid = 1'b0;
        i_mac_type    = 16'd0;
        i_mac_len     = 16'd0;
        i_mac_data    = 8'd0;
        i_mac_last    = 1'b0;
        i_mac_valid   = 1'b0;
        test_reset();
        test_basic();
        test_bad_csum();
        test_padding();
        test_local_ip();
        test_truncated();
        test_filters();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
